// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and constants for the rst_seq reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT,
      HOLD,
      STEP,
      DONE
   } state_t;

   localparam int unsigned CAUSE_W = 2;

   localparam logic [CAUSE_W-1:0] CAUSE_POR = 2'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_EXT = 2'd1;
   localparam logic [CAUSE_W-1:0] CAUSE_SW  = 2'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_WDT = 2'd3;

   // Largest of three cycle counts; sizes the shared hold/step/watchdog counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: flop chain with asynchronous set; output reads "in reset"
// (high) while rst is asserted and follows d after STAGES clock edges.
module rst_seq_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift d toward the output; shift form also covers a one-flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '1;
      else     chain <= (chain << 1) | STAGES'(d);
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// rst_seq: ordered multi-channel reset sequencer with latched reset cause.
// Optional watchdog enabled by defining RST_SEQ_WDT_EN.
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STEP_CYCLES = 8,
   parameter int unsigned WDT_CYCLES  = 1024
) (
   input  logic               wb_clk,
   input  logic               wb_rst,
   input  logic               ext_rst_req_i,
   input  logic               sw_rst_i,
   input  logic               wdt_kick_i,
   output logic [NUM_CH-1:0]  rst_o,
   output logic               done_o,
   output logic [CAUSE_W-1:0] cause_o
);

   localparam int unsigned CNT_W = $clog2(max3(HOLD_CYCLES, STEP_CYCLES, WDT_CYCLES) + 1);
   localparam int unsigned CH_W  = $clog2(NUM_CH) + 1;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [CH_W-1:0]   ch;
   logic              rst_sync;
   logic              ext_sync;
   logic              wdt_fire;

   // The state register itself is the last synchroniser stage, so the
   // chains are one flop shorter than SYNC_STAGES.
   rst_seq_sync #(.STAGES(SYNC_STAGES - 1)) u_sync_rst (
      .clk (wb_clk),
      .rst (wb_rst),
      .d   (1'b0),
      .q   (rst_sync)
   );

   rst_seq_sync #(.STAGES(SYNC_STAGES - 1)) u_sync_ext (
      .clk (wb_clk),
      .rst (wb_rst),
      .d   (ext_rst_req_i),
      .q   (ext_sync)
   );

   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef RST_SEQ_WDT_EN
   assign wdt_fire = (state == DONE) && !wdt_kick_i && (cnt == CNT_W'(WDT_CYCLES - 1));
`else
   logic unused_kick;
   assign unused_kick = wdt_kick_i;
   assign wdt_fire    = 1'b0;
`endif

   // Sequencer: request arbitration, hold/step timing and registered outputs.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state   <= ASSERT;
         cnt     <= '0;
         ch      <= '0;
         rst_o   <= '1;
         done_o  <= 1'b0;
         cause_o <= CAUSE_POR;
      end else if (rst_sync) begin
         state  <= ASSERT;
         cnt    <= '0;
         ch     <= '0;
         rst_o  <= '1;
         done_o <= 1'b0;
      end else if (ext_sync) begin
         state   <= ASSERT;
         cnt     <= '0;
         ch      <= '0;
         rst_o   <= '1;
         done_o  <= 1'b0;
         cause_o <= CAUSE_EXT;
      end else if (wdt_fire) begin
         state   <= HOLD;
         cnt     <= '0;
         ch      <= '0;
         rst_o   <= '1;
         done_o  <= 1'b0;
         cause_o <= CAUSE_WDT;
      end else if (sw_rst_i && (state != ASSERT)) begin
         state   <= HOLD;
         cnt     <= '0;
         ch      <= '0;
         rst_o   <= '1;
         done_o  <= 1'b0;
         cause_o <= CAUSE_SW;
      end else begin
         case (state)
            ASSERT: begin
               state <= HOLD;
               cnt   <= '0;
            end
            HOLD: begin
               if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                  rst_o[0] <= 1'b0;
                  cnt      <= '0;
                  if (NUM_CH == 1) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= STEP;
                     ch    <= CH_W'(1);
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            STEP: begin
               if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
                  // Masking keeps released channels released.
                  rst_o <= rst_o & ~(NUM_CH'(1) << ch);
                  cnt   <= '0;
                  if (ch == CH_W'(NUM_CH - 1)) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     ch <= ch + 1'b1;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            DONE: begin
`ifdef RST_SEQ_WDT_EN
               if (wdt_kick_i) cnt <= '0;
               else            cnt <= cnt_inc;
`endif
            end
            default: state <= ASSERT;
         endcase
      end
   end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench for rst_seq. Watchdog checks compile only
// when RST_SEQ_WDT_EN is defined.
module tb_rst_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Main instance: 3 channels
   logic       rst3 = 1'b1, ext3 = 1'b0, sw3 = 1'b0, kick3 = 1'b0;
   logic [2:0] r3;
   logic       d3;
   logic [1:0] c3;

   rst_seq #(.NUM_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STEP_CYCLES(8), .WDT_CYCLES(1024)) u3 (
      .wb_clk        (clk),
      .wb_rst        (rst3),
      .ext_rst_req_i (ext3),
      .sw_rst_i      (sw3),
      .wdt_kick_i    (kick3),
      .rst_o         (r3),
      .done_o        (d3),
      .cause_o       (c3)
   );

   // Single channel, HOLD=1
   logic       rst1 = 1'b1, ext1 = 1'b0, sw1 = 1'b0, kick1 = 1'b0;
   logic [0:0] r1;
   logic       d1;
   logic [1:0] c1;

   rst_seq #(.NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STEP_CYCLES(8), .WDT_CYCLES(1024)) u1 (
      .wb_clk        (clk),
      .wb_rst        (rst1),
      .ext_rst_req_i (ext1),
      .sw_rst_i      (sw1),
      .wdt_kick_i    (kick1),
      .rst_o         (r1),
      .done_o        (d1),
      .cause_o       (c1)
   );

`ifdef RST_SEQ_WDT_EN
   logic       rstw = 1'b1, extw = 1'b0, sww = 1'b0, kickw = 1'b0;
   logic [2:0] rw;
   logic       dw;
   logic [1:0] cw;

   rst_seq #(.NUM_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STEP_CYCLES(8), .WDT_CYCLES(32)) uw (
      .wb_clk        (clk),
      .wb_rst        (rstw),
      .ext_rst_req_i (extw),
      .sw_rst_i      (sww),
      .wdt_kick_i    (kickw),
      .rst_o         (rw),
      .done_o        (dw),
      .cause_o       (cw)
   );
`endif

   typedef struct {
      int unsigned id;
      int unsigned cy;
      logic [5:0]  val;   // {rst[2:0], done, cause[1:0]}
   } ev_t;

   ev_t sb[$];
   int  checks   = 0;
   int  failures = 0;

   task automatic expect_ev(input int unsigned id, input int unsigned cy,
                            input logic [2:0] r, input logic d, input logic [1:0] c);
      sb.push_back('{id, cy, {r, d, c}});
   endtask

   task automatic goto(input int unsigned e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: any output change of any DUT must match the next queued event
   logic [5:0] prev [3] = '{6'b111_0_00, 6'b001_0_00, 6'b111_0_00};
   logic [5:0] now  [3];
   logic [5:0] rst_exp [3] = '{6'b111_0_00, 6'b001_0_00, 6'b111_0_00};
   ev_t        e;

   always @(negedge clk) begin
      now[0] = {r3, d3, c3};
      now[1] = {2'b00, r1, d1, c1};
`ifdef RST_SEQ_WDT_EN
      now[2] = {rw, dw, cw};
`else
      now[2] = 6'b111_0_00;
`endif
      if (cyc == 1) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (now[i] !== rst_exp[i]) begin
               failures++;
               $display("FAIL reset_state dut=%0d got=%b required=%b", i, now[i], rst_exp[i]);
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (now[i] !== prev[i]) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change dut=%0d cyc=%0d got=%b required=none", i, cyc, now[i]);
            end else begin
               e = sb.pop_front();
               if (e.id != i || e.cy != cyc || e.val !== now[i]) begin
                  failures++;
                  $display("FAIL event got dut=%0d cyc=%0d val=%b required dut=%0d cyc=%0d val=%b",
                           i, cyc, now[i], e.id, e.cy, e.val);
               end
            end
            prev[i] = now[i];
         end
      end
   end

   initial begin
      // POR: edge 1 = abs 4; ch0 at rel 18, ch1 26, ch2 34
      expect_ev(0, 21, 3'b110, 1'b0, 2'd0);
      expect_ev(0, 29, 3'b100, 1'b0, 2'd0);
      expect_ev(0, 37, 3'b000, 1'b1, 2'd0);
      goto(3);  rst3 = 1'b0;

      // Software pulse sampled at abs 104 (rel 101)
      expect_ev(0, 104, 3'b111, 1'b0, 2'd2);
      expect_ev(0, 120, 3'b110, 1'b0, 2'd2);
      expect_ev(0, 128, 3'b100, 1'b0, 2'd2);
      expect_ev(0, 136, 3'b000, 1'b1, 2'd2);
      goto(103); sw3 = 1'b1;
      goto(104); sw3 = 1'b0;

      // Ext request during STEP; sw during ASSERT is ignored
      expect_ev(0, 201, 3'b111, 1'b0, 2'd2);
      expect_ev(0, 217, 3'b110, 1'b0, 2'd2);
      expect_ev(0, 222, 3'b111, 1'b0, 2'd1);
      expect_ev(0, 248, 3'b110, 1'b0, 2'd1);
      expect_ev(0, 256, 3'b100, 1'b0, 2'd1);
      expect_ev(0, 264, 3'b000, 1'b1, 2'd1);
      goto(200); sw3 = 1'b1;
      goto(201); sw3 = 1'b0;
      goto(220); ext3 = 1'b1;
      goto(230); ext3 = 1'b0;
      goto(231); sw3 = 1'b1;
      goto(232); sw3 = 1'b0;

      // Set cause to SW, then ext and sw on the same synchronised edge
      expect_ev(0, 281, 3'b111, 1'b0, 2'd2);
      expect_ev(0, 297, 3'b110, 1'b0, 2'd2);
      expect_ev(0, 305, 3'b100, 1'b0, 2'd2);
      expect_ev(0, 313, 3'b000, 1'b1, 2'd2);
      expect_ev(0, 352, 3'b111, 1'b0, 2'd1);
      expect_ev(0, 373, 3'b110, 1'b0, 2'd1);
      expect_ev(0, 381, 3'b100, 1'b0, 2'd1);
      expect_ev(0, 389, 3'b000, 1'b1, 2'd1);
      goto(280); sw3 = 1'b1;
      goto(281); sw3 = 1'b0;
      goto(350); ext3 = 1'b1;
      goto(351); sw3 = 1'b1;
      goto(352); sw3 = 1'b0;
      goto(355); ext3 = 1'b0;

      // wb_rst pulsed mid-HOLD
      expect_ev(0, 401, 3'b111, 1'b0, 2'd2);
      expect_ev(0, 405, 3'b111, 1'b0, 2'd0);
      expect_ev(0, 425, 3'b110, 1'b0, 2'd0);
      expect_ev(0, 433, 3'b100, 1'b0, 2'd0);
      expect_ev(0, 441, 3'b000, 1'b1, 2'd0);
      goto(400); sw3 = 1'b1;
      goto(401); sw3 = 1'b0;
      goto(405); rst3 = 1'b1;
      goto(407); rst3 = 1'b0;

      // NUM_CH=1, HOLD=1: release and done together at rel edge 3
      expect_ev(1, 503, 3'b000, 1'b1, 2'd0);
      expect_ev(1, 521, 3'b001, 1'b0, 2'd2);
      expect_ev(1, 522, 3'b000, 1'b1, 2'd2);
      goto(500); rst1 = 1'b0;
      goto(520); sw1 = 1'b1;
      goto(521); sw1 = 1'b0;

`ifdef RST_SEQ_WDT_EN
      // Watchdog: kicks every 20 cycles hold it off; last kick at 711 -> fire at 743
      expect_ev(2, 618, 3'b110, 1'b0, 2'd0);
      expect_ev(2, 626, 3'b100, 1'b0, 2'd0);
      expect_ev(2, 634, 3'b000, 1'b1, 2'd0);
      expect_ev(2, 743, 3'b111, 1'b0, 2'd3);
      expect_ev(2, 759, 3'b110, 1'b0, 2'd3);
      expect_ev(2, 767, 3'b100, 1'b0, 2'd3);
      expect_ev(2, 775, 3'b000, 1'b1, 2'd3);
      goto(600); rstw = 1'b0;
      for (int k = 0; k < 4; k++) begin
         goto(650 + 20 * k); kickw = 1'b1;
         goto(651 + 20 * k); kickw = 1'b0;
      end
      goto(790);
`else
      goto(560);
`endif

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL pending_events got=%0d required=0 next_cyc=%0d", sb.size(), sb[0].cy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
